// File: rtl/ttl_74138_cs_sched_if.sv
// Request and decoder-pin bundle between bus-master request logic,
// the chip-select scheduler and the 74138 decoder.
interface ttl_74138_cs_sched_if;
  logic [7:0] req;
  logic [2:0] A;
  logic       E1_n;
  logic       E2_n;
  logic       E3;
  logic [7:0] gnt;
  logic       busy;

  // Scheduler side: samples requests, drives decoder pins and grants.
  modport master (
    input  req,
    output A, E1_n, E2_n, E3, gnt, busy
  );

  // Requester/decoder side.
  modport slave (
    output req,
    input  A, E1_n, E2_n, E3, gnt, busy
  );
endinterface

// File: rtl/ttl_74138_cs_sched.sv
// Round-robin chip-select scheduler for a 74138 3-to-8 decoder.
// Holds the address stable for SETUP_CYC disabled cycles before each enable
// window and HOLD_CYC disabled cycles after it; a window lasts at most
// MAX_ACTIVE cycles. All decoder pins and status outputs are registered.
module ttl_74138_cs_sched #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned MAX_ACTIVE = 16
) (
  input logic                   clk,
  input logic                   reset,
  ttl_74138_cs_sched_if.master  bus
);

  localparam int unsigned PH_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned ACT_W  = $clog2(MAX_ACTIVE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACTIVE,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        addr_q, addr_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [ACT_W-1:0]  act_q, act_d;
  logic [2:0]        pick_c;
  logic              hit_c;
  logic              en_d;

  // Round-robin pick: first set request at ptr, ptr+1 ... ptr+7 (mod 8).
  always_comb begin
    pick_c = ptr_q;
    hit_c  = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (bus.req[ptr_q + 3'(k)]) begin
        pick_c = ptr_q + 3'(k);
        hit_c  = 1'b1;
      end
    end
  end

  // Next-state logic for the setup / active / hold sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    ph_d    = ph_q;
    act_d   = act_q;
    case (state_q)
      S_IDLE: begin
        if (hit_c) begin
          state_d = S_SETUP;
          addr_d  = pick_c;
          ph_d    = '0;
          act_d   = '0;
        end
      end
      S_SETUP: begin
        if (ph_q == PH_W'(SETUP_CYC - 1)) begin
          ph_d    = '0;
          // A request withdrawn during setup aborts without an enable cycle.
          state_d = bus.req[addr_q] ? S_ACTIVE : S_HOLD;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_ACTIVE: begin
        if (act_q != ACT_W'(MAX_ACTIVE)) begin
          act_d = act_q + ACT_W'(1);
        end
        if (!bus.req[addr_q] || (act_d == ACT_W'(MAX_ACTIVE))) begin
          state_d = S_HOLD;
          ph_d    = '0;
          ptr_d   = addr_q + 3'd1;
        end
      end
      S_HOLD: begin
        if (ph_q == PH_W'(HOLD_CYC - 1)) begin
          ph_d    = '0;
          state_d = S_IDLE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign en_d = (state_d == S_ACTIVE);

  // State register and registered decoder pins; reset disables the decoder at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      addr_q   <= '0;
      ph_q     <= '0;
      act_q    <= '0;
      bus.A    <= '0;
      bus.E1_n <= 1'b1;
      bus.E2_n <= 1'b1;
      bus.E3   <= 1'b0;
      bus.gnt  <= '0;
      bus.busy <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      ph_q     <= ph_d;
      act_q    <= act_d;
      bus.A    <= addr_d;
      bus.E1_n <= ~en_d;
      bus.E2_n <= ~en_d;
      bus.E3   <= en_d;
      bus.gnt  <= en_d ? 8'(8'h01 << addr_d) : 8'h00;
      bus.busy <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_ttl_74138_cs_sched.sv
// Scoreboard bench for ttl_74138_cs_sched: three parameter sets share one
// random request stream; a transaction-level model predicts every grant.
module tb_ttl_74138_cs_sched;

  localparam int NCFG = 3;
  localparam int NCYC = 3000;
  localparam int PAD  = 64;
  localparam int unsigned CFG_SU [NCFG] = '{1, 3, 2};
  localparam int unsigned CFG_HO [NCFG] = '{1, 1, 3};
  localparam int unsigned CFG_MA [NCFG] = '{16, 4, 1};
  localparam logic [14:0] IDLE_ST = {3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

  typedef struct {
    int idx;
    int t_busy;
    int t_en;
    int len;
    int t_idle;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'h00;
  int         edge_n;
  bit         mon_en = 1'b0;
  int         checks = 0;
  int         failures = 0;

  logic [7:0] req_arr [NCYC+PAD+1];
  rec_t       exp_q [NCFG][$];
  rec_t       cur [NCFG];
  bit         have [NCFG];
  bit         prev_busy [NCFG];
  int         en_cnt [NCFG];

  logic [2:0] a_w [NCFG];
  logic       e1_w [NCFG];
  logic       e2_w [NCFG];
  logic       e3_w [NCFG];
  logic [7:0] gnt_w [NCFG];
  logic       busy_w [NCFG];

  always #5 clk = ~clk;

  ttl_74138_cs_sched_if bus [NCFG] ();

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    assign bus[g].req = req;
    assign a_w[g]    = bus[g].A;
    assign e1_w[g]   = bus[g].E1_n;
    assign e2_w[g]   = bus[g].E2_n;
    assign e3_w[g]   = bus[g].E3;
    assign gnt_w[g]  = bus[g].gnt;
    assign busy_w[g] = bus[g].busy;

    ttl_74138_cs_sched #(
      .SETUP_CYC (CFG_SU[g]),
      .HOLD_CYC  (CFG_HO[g]),
      .MAX_ACTIVE(CFG_MA[g])
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus[g])
    );
  end

  // Count rising edges since reset release; edge 1 samples req_arr[1].
  always @(posedge clk or posedge reset) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  task automatic chk(input int k, input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s cfg%0d edge=%0d: actual=%0d expected=%0d", name, k, edge_n, act, exp);
    end
  endtask

  function automatic logic [14:0] status(input int k);
    return {a_w[k], e1_w[k], e2_w[k], e3_w[k], gnt_w[k], busy_w[k]};
  endfunction

  function automatic bit enabled(input int k);
    return !e1_w[k] && !e2_w[k] && e3_w[k];
  endfunction

  // Random request segments: idle, held value, all-ones, single bit, noise, 1-cycle pulse.
  task automatic gen_stimulus();
    int c = 1;
    for (int i = 0; i <= NCYC + PAD; i++) req_arr[i] = 8'h00;
    while (c <= NCYC) begin
      int         len  = int'($urandom_range(1, 40));
      int         mode = int'($urandom_range(0, 5));
      logic [7:0] val  = 8'($urandom);
      logic [7:0] one  = 8'(8'h01 << $urandom_range(0, 7));
      for (int j = 0; j < len && c <= NCYC; j++) begin
        case (mode)
          0:       req_arr[c] = 8'h00;
          1:       req_arr[c] = val;
          2:       req_arr[c] = 8'hFF;
          3:       req_arr[c] = one;
          4:       req_arr[c] = 8'($urandom);
          default: req_arr[c] = (j == 0) ? val : 8'h00;
        endcase
        c++;
      end
    end
    req_arr[1] = 8'h00;
    req_arr[2] = 8'h00;
  endtask

  // Transaction model: walk the request timeline grant by grant.
  task automatic build_expect(input int k);
    int   su  = int'(CFG_SU[k]);
    int   ho  = int'(CFG_HO[k]);
    int   ma  = int'(CFG_MA[k]);
    int   t   = 1;
    int   ptr = 0;
    int   i;
    int   s;
    int   len;
    int   x;
    rec_t r;
    while (t <= NCYC) begin
      if (req_arr[t] == 8'h00) begin
        t++;
        continue;
      end
      i = -1;
      for (int j = 0; j < 8; j++) begin
        if (i < 0 && req_arr[t][(ptr + j) % 8]) i = (ptr + j) % 8;
      end
      s = t + su;
      if (req_arr[s][i]) begin
        len = 1;
        while (len < ma && req_arr[s + len][i]) len++;
        r.t_en = s;
        x      = s + len;
        ptr    = (i + 1) % 8;
      end else begin
        len    = 0;
        r.t_en = -1;
        x      = s;
      end
      r.idx    = i;
      r.t_busy = t;
      r.len    = len;
      r.t_idle = x + ho;
      exp_q[k].push_back(r);
      t = x + ho + 1;
    end
  endtask

  // Monitor: per cycle pin coherence, grant encoding and per-transaction timing.
  task automatic monitor();
    bit         en;
    logic [7:0] eg;
    for (int k = 0; k < NCFG; k++) begin
      have[k] = 1'b0;
      prev_busy[k] = 1'b0;
      en_cnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int k = 0; k < NCFG; k++) begin
          en = enabled(k);
          chk(k, en || (e1_w[k] && e2_w[k] && !e3_w[k]), "enable_lines",
              int'({e1_w[k], e2_w[k], e3_w[k]}), 6);
          eg = en ? 8'(8'h01 << a_w[k]) : 8'h00;
          chk(k, gnt_w[k] == eg, "gnt", int'(gnt_w[k]), int'(eg));
          if (busy_w[k] && !prev_busy[k]) begin
            if (exp_q[k].size() == 0) begin
              chk(k, 1'b0, "unexpected_txn", int'(a_w[k]), -1);
            end else begin
              cur[k]    = exp_q[k].pop_front();
              have[k]   = 1'b1;
              en_cnt[k] = 0;
              chk(k, edge_n == cur[k].t_busy, "busy_rise_edge", edge_n, cur[k].t_busy);
              chk(k, int'(a_w[k]) == cur[k].idx, "addr_select", int'(a_w[k]), cur[k].idx);
            end
          end
          if (busy_w[k] && have[k]) begin
            chk(k, int'(a_w[k]) == cur[k].idx, "addr_stable", int'(a_w[k]), cur[k].idx);
            if (en) begin
              if (en_cnt[k] == 0) chk(k, edge_n == cur[k].t_en, "enable_start", edge_n, cur[k].t_en);
              en_cnt[k]++;
            end
          end else if (en) begin
            chk(k, 1'b0, "enable_outside_txn", int'(a_w[k]), -1);
          end
          if (!busy_w[k] && prev_busy[k] && have[k]) begin
            chk(k, en_cnt[k] == cur[k].len, "enable_len", en_cnt[k], cur[k].len);
            chk(k, edge_n == cur[k].t_idle, "idle_edge", edge_n, cur[k].t_idle);
            have[k] = 1'b0;
          end
          prev_busy[k] = busy_w[k];
        end
      end
    end
  endtask

  initial begin
    int n;
    gen_stimulus();
    for (int k = 0; k < NCFG; k++) build_expect(k);
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    for (int k = 0; k < NCFG; k++)
      chk(k, status(k) == IDLE_ST, "reset_outputs", int'(status(k)), int'(IDLE_ST));

    // Single request on /Y3, then asynchronous reset in the middle of the window.
    reset = 1'b0;
    req   = 8'h08;
    n = 0;
    while (!enabled(0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(0, enabled(0), "reach_active", n, 2);
    chk(0, a_w[0] == 3'd3, "single_addr", int'(a_w[0]), 3);
    chk(0, gnt_w[0] == 8'h08, "single_gnt", int'(gnt_w[0]), 8);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < NCFG; k++)
      chk(k, status(k) == IDLE_ST, "async_reset", int'(status(k)), int'(IDLE_ST));
    @(negedge clk);
    @(negedge clk);

    // Random phase against the model.
    reset  = 1'b0;
    req    = req_arr[1];
    mon_en = 1'b1;
    for (int c = 2; c <= NCYC + PAD; c++) begin
      @(negedge clk);
      req = req_arr[c];
      if (c == 3) begin
        for (int k = 0; k < NCFG; k++)
          chk(k, status(k) == IDLE_ST, "idle_after_reset", int'(status(k)), int'(IDLE_ST));
      end
    end
    @(negedge clk);
    mon_en = 1'b0;
    for (int k = 0; k < NCFG; k++) begin
      chk(k, exp_q[k].size() == 0, "drain_queue", exp_q[k].size(), 0);
      chk(k, !have[k], "drain_open_txn", int'(have[k]), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
